// File: rtl/gtxe2_chnl_rx_oob.sv
// SATA OOB detector for the RX channel model: classifies burst/gap timing of the
// per-word line-idle indication into COMINIT/COMWAKE pulses and a filtered RXELECIDLE.
module gtxe2_chnl_rx_oob #(
  parameter int BURST_MIN       = 8,
  parameter int BURST_MAX       = 24,
  parameter int WAKE_GAP_MIN    = 8,
  parameter int WAKE_GAP_MAX    = 24,
  parameter int INIT_GAP_MIN    = 36,
  parameter int INIT_GAP_MAX    = 60,
  parameter int BURST_CNT       = 4,
  parameter int ELECIDLE_FILTER = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic idle_in,
  output logic RXELECIDLE,
  output logic RXCOMINITDET,
  output logic RXCOMWAKEDET
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DATA} state_t;
  typedef enum logic [1:0] {C_NONE, C_WAKE, C_INIT, C_BAD} cls_t;

  localparam int NB_W = $clog2(BURST_CNT + 1);
  localparam int IR_W = $clog2(ELECIDLE_FILTER + 1);

  localparam logic [CNT_W-1:0] LEN_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] LEN_SAT      = '1;
  localparam logic [CNT_W-1:0] L_BURST_MIN  = CNT_W'(BURST_MIN);
  localparam logic [CNT_W-1:0] L_BURST_MAX  = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] L_WAKE_MIN   = CNT_W'(WAKE_GAP_MIN);
  localparam logic [CNT_W-1:0] L_WAKE_MAX   = CNT_W'(WAKE_GAP_MAX);
  localparam logic [CNT_W-1:0] L_INIT_MIN   = CNT_W'(INIT_GAP_MIN);
  localparam logic [CNT_W-1:0] L_INIT_MAX   = CNT_W'(INIT_GAP_MAX);
  localparam logic [NB_W-1:0]  NB_LAST      = NB_W'(BURST_CNT - 1);
  localparam logic [IR_W-1:0]  IR_FULL      = IR_W'(ELECIDLE_FILTER);
  localparam logic [IR_W-1:0]  IR_LAST      = IR_W'(ELECIDLE_FILTER - 1);

  state_t            state;
  cls_t              cls;
  cls_t              gap_cls;
  logic [CNT_W-1:0]  len;
  logic [NB_W-1:0]   nbursts;
  logic [IR_W-1:0]   idle_run;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == LEN_SAT) ? v : v + LEN_ONE;
  endfunction

  function automatic cls_t classify_gap(input logic [CNT_W-1:0] v);
    if (v >= L_WAKE_MIN && v <= L_WAKE_MAX) return C_WAKE;
    if (v >= L_INIT_MIN && v <= L_INIT_MAX) return C_INIT;
    return C_BAD;
  endfunction

  assign gap_cls = classify_gap(len);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      len          <= '0;
      nbursts      <= '0;
      cls          <= C_NONE;
      RXCOMINITDET <= 1'b0;
      RXCOMWAKEDET <= 1'b0;
    end else begin
      RXCOMINITDET <= 1'b0;
      RXCOMWAKEDET <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!idle_in) begin
            state   <= S_BURST;
            len     <= LEN_ONE;
            nbursts <= '0;
            cls     <= C_NONE;
          end
        end
        S_BURST: begin
          if (!idle_in) begin
            // A burst longer than any OOB burst is ordinary traffic.
            if (len >= L_BURST_MAX) state <= S_DATA;
            else len <= sat_inc(len);
          end else if (len < L_BURST_MIN) begin
            state <= S_IDLE;
          end else if (nbursts == NB_LAST) begin
            RXCOMWAKEDET <= (cls == C_WAKE);
            RXCOMINITDET <= (cls == C_INIT);
            state        <= S_IDLE;
            nbursts      <= '0;
            cls          <= C_NONE;
          end else begin
            nbursts <= nbursts + NB_W'(1);
            len     <= LEN_ONE;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (idle_in) begin
            if (len >= L_INIT_MAX) state <= S_IDLE;
            else len <= sat_inc(len);
          end else begin
            state <= S_BURST;
            len   <= LEN_ONE;
            // A bad or class-changing gap restarts counting at the burst now starting.
            if (gap_cls == C_BAD || (cls != C_NONE && gap_cls != cls)) begin
              nbursts <= '0;
              cls     <= C_NONE;
            end else begin
              cls <= gap_cls;
            end
          end
        end
        S_DATA: begin
          if (idle_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Electrical-idle filter, independent of the OOB sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_run   <= '0;
      RXELECIDLE <= 1'b1;
    end else if (!idle_in) begin
      idle_run   <= '0;
      RXELECIDLE <= 1'b0;
    end else begin
      if (idle_run != IR_FULL) idle_run <= idle_run + IR_W'(1);
      if (idle_run >= IR_LAST) RXELECIDLE <= 1'b1;
    end
  end

endmodule

// File: doc/gtxe2_chnl_rx_oob.md
Name: gtxe2_chnl_rx_oob

Overview:
- SATA OOB detector on the receive side of the channel model.
- Consumes the per-word line-idle indication that the RX deserializer derives from the serial line driven by the TX serializer/OOB path.
- Classifies burst/gap timing into COMINIT/COMWAKE detections and produces a filtered RXELECIDLE status.
- Single clock domain: RX word clock.

Parameters:
- BURST_MIN, 8: minimum valid burst length, clk cycles.
- BURST_MAX, 24: maximum valid burst length, clk cycles.
- WAKE_GAP_MIN, 8: minimum COMWAKE gap, cycles.
- WAKE_GAP_MAX, 24: maximum COMWAKE gap, cycles.
- INIT_GAP_MIN, 36: minimum COMINIT gap, cycles.
- INIT_GAP_MAX, 60: maximum COMINIT gap, cycles. Constraint: WAKE_GAP_MAX < INIT_GAP_MIN.
- BURST_CNT, 4: valid bursts required per detection. Must be >= 2.
- ELECIDLE_FILTER, 4: consecutive idle samples before RXELECIDLE asserts.
- CNT_W, 8: length counter width. Counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  RX word clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low (0 = reset).
- idle_in  input  1  line electrically idle during this word (1 = idle, 0 = activity).
- RXELECIDLE  output  1  filtered electrical-idle status.
- RXCOMINITDET  output  1  one-cycle pulse: COMINIT sequence detected.
- RXCOMWAKEDET  output  1  one-cycle pulse: COMWAKE sequence detected.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=S_IDLE; len=0; nbursts=0; class=NONE; idle_run=0.
  - RXELECIDLE=1, RXCOMINITDET=0, RXCOMWAKEDET=0.
  - Reset mid-sequence discards all progress. No detection pulse may follow reset release without a full new sequence.
- All outputs are registered.
- State machine, one idle_in sample per cycle:
  - S_IDLE: idle_in=0 -> S_BURST, len=1, nbursts=0, class=NONE. Otherwise stay.
  - S_BURST, idle_in=0:
    - len++.
    - If len would exceed BURST_MAX -> S_DATA; sequence aborted (continuous traffic).
  - S_BURST, idle_in=1 (burst end):
    - len<BURST_MIN -> S_IDLE, abort.
    - Otherwise valid burst: nbursts++.
    - If new nbursts==BURST_CNT: pulse RXCOMWAKEDET (class WAKE) or RXCOMINITDET (class INIT) high for exactly the next cycle, then -> S_IDLE.
    - Else -> S_GAP, len=1.
  - S_GAP, idle_in=1: len++. If len would exceed INIT_GAP_MAX -> S_IDLE, abort.
  - S_GAP, idle_in=0: classify the gap length len:
    - WAKE if WAKE_GAP_MIN<=len<=WAKE_GAP_MAX.
    - INIT if INIT_GAP_MIN<=len<=INIT_GAP_MAX.
    - Else invalid.
    - Invalid gap, or class!=NONE and gap class differs from class: restart with nbursts=0, class=NONE. The current burst counts as a new first burst.
    - Otherwise class=gap class.
    - Either way -> S_BURST, len=1.
  - S_DATA: stay while idle_in=0. idle_in=1 -> S_IDLE.
- Detection latency: the pulse is high in the cycle immediately after the edge that samples the first idle cycle following the BURST_CNT-th burst.
- RXCOMINITDET and RXCOMWAKEDET are never high simultaneously. Each is never high two consecutive cycles.
- RXELECIDLE:
  - idle_run counts consecutive idle_in=1 samples, saturating at ELECIDLE_FILTER.
  - RXELECIDLE=1 on the edge where idle_run reaches ELECIDLE_FILTER.
  - RXELECIDLE=0 on the first edge sampling idle_in=0, i.e. 1-cycle latency.
  - Independent of the OOB state machine.
- Counters saturate and never wrap. An idle of 2^CNT_W or more cycles is handled as over-limit.

Test Plan:
- COMWAKE: after reset release, 4×(16 active, 16 idle) -> one RXCOMWAKEDET pulse, 1 cycle wide, in the cycle after the first idle sample following burst 4. RXCOMINITDET stays 0.
- COMINIT: 4×(16 active, 48 idle) -> exactly one RXCOMINITDET pulse at the same relative timing. RXCOMWAKEDET stays 0. Repeating the sequence gives a second pulse.
- Mixed/invalid gaps: bursts of 16 with gaps 16,48,16,16,16 -> the class change at the 48 gap restarts the count. One RXCOMWAKEDET only after 4 consecutive WAKE-spaced bursts (the 48-gap burst counts as first). A gap of 30 (between classes) -> no pulse until 4 fresh bursts.
- Bad burst lengths: burst of 4 cycles -> abort. Burst of 30 active cycles -> S_DATA, no detection until idle then a full new sequence. Gap of 70 -> abort.
- Reset mid-sequence: reset=0 for 1 cycle after burst 3 of a COMWAKE; the 4th burst produces no pulse. RXELECIDLE=1 and both det outputs =0 during and after reset.
- RXELECIDLE filter: idle_in 1 for 3 cycles then 0 -> RXELECIDLE falls 1 cycle after the 0 sample and does not re-rise. idle_in 1 for 4 cycles -> rises on the 4th idle edge.
